// File: rtl/mem_bus_pkg.sv
// Shared definitions for the uP memory bus.
//   MEM_DW / MEM_ADW : bus data and address widths.
//   mem_state_e      : responder FSM states.
//   addr_decode()    : block-select compare on the address bits above the RAM index.
package mem_bus_pkg;

    localparam int MEM_DW  = 16;
    localparam int MEM_ADW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2
    } mem_state_e;

    // True when addr falls in the DEPTH-aligned window starting at base.
    // aw is the RAM index width. Only the bits above the index are compared.
    function automatic logic addr_decode(input logic [MEM_ADW-1:0] addr,
                                         input logic [MEM_ADW-1:0] base,
                                         input int                 aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM for the memory responder.
//   i_clk   : clock, rising edge
//   i_we    : write enable, writes i_wdata to RAM[i_addr]
//   i_re    : read enable, registers RAM[i_addr] into o_rdata
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data (holds when i_re is low)
// Neither the array nor the read register is reset, so the RAM can be
// inferred as block RAM.
module mem_responder_ram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [MEM_DW-1:0] i_wdata,
    output logic [MEM_DW-1:0] o_rdata
);

    logic [MEM_DW-1:0] mem [DEPTH];
    logic [MEM_DW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint of the uP memory bus.
// Writes that decode to this block are committed to the on-chip RAM.
// Reads are answered on the shared tristate data line RD_LAT edges after
// the read is first sampled, provided the address is held stable.
//   i_clk      : system clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_memAddr  : bus word address
//   i_memWr    : 1 = write, 0 = read (qualified by i_memEn)
//   i_memEn    : bus access enable
//   io_memData : shared data line, driven only while o_rdValid is high
//   o_rdValid  : read data valid on io_memData
//   o_hit      : combinational decode of i_memEn and the address window
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int                 DEPTH  = 1024,
    parameter logic [MEM_ADW-1:0] BASE   = 16'h0000,
    parameter int                 RD_LAT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [MEM_ADW-1:0] i_memAddr,
    input  logic               i_memWr,
    input  logic               i_memEn,
    inout  wire  [MEM_DW-1:0]  io_memData,
    output logic               o_rdValid,
    output logic               o_hit
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [2:0] LAT_RELOAD = 3'(RD_LAT - 1);

    mem_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              rd_valid_q, rd_valid_d;

    logic              hit, rd_req, wr_req, same_addr, accept, ram_re;
    logic [AW-1:0]     idx;
    logic [MEM_DW-1:0] ram_rdata;

    assign hit       = i_memEn & addr_decode(i_memAddr, BASE, AW);
    assign idx       = i_memAddr[AW-1:0];
    assign rd_req    = hit & ~i_memWr;
    assign wr_req    = hit & i_memWr;
    assign same_addr = (idx == addr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_valid_d = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    accept = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rd_req && same_addr) begin
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (rd_req) begin
                    accept = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (rd_req && same_addr) begin
                    rd_valid_d = 1'b1;
                end else if (rd_req) begin
                    accept = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new read (from idle or an address change) restarts the latency.
        // With RD_LAT == 1 the RAM read happens on the accepting edge, so
        // the wait phase is skipped entirely.
        if (accept) begin
            addr_d  = idx;
            cnt_d   = LAT_RELOAD;
            state_d = (RD_LAT == 1) ? ST_DRIVE : ST_WAIT;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // The RAM output register loads on every edge that leaves the FSM in
    // DRIVE. The bus address equals the latched one on those edges, so the
    // live index is used to read the RAM.
    assign ram_re = (state_d == ST_DRIVE);

    mem_responder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_req),
        .i_re    (ram_re),
        .i_addr  (idx),
        .i_wdata (io_memData),
        .o_rdata (ram_rdata)
    );

    // The drive enable comes only from a flop, so i_memWr has no
    // combinational path to the tristate.
    assign io_memData = rd_valid_q ? ram_rdata : {MEM_DW{1'bz}};
    assign o_rdValid  = rd_valid_q;
    assign o_hit      = hit;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Four instances share the bus control signals:
//   u0 BASE 0x0000 RD_LAT 2, u1 BASE 0x0000 RD_LAT 1,
//   u2 BASE 0x0000 RD_LAT 7, u3 BASE 0x0400 RD_LAT 2.
// Each instance has its own data line. Expected read words and the cycle
// at which each must first appear are queued when a read is driven. They
// are popped when that instance raises rdValid.
module tb_mem_responder;

    typedef struct {
        int          inst;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, wr, tb_drv;
    logic [15:0] addr, wdata;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    wire  [15:0] d0, d1, d2, d3;
    logic        rv0, rv1, rv2, rv3;
    logic        h0, h1, h2, h3;
    logic [3:0]  rdv, hits, rdv_prev;

    exp_t        sb_q[$];
    logic [15:0] mem_m [4][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign d0 = tb_drv ? wdata : 16'hzzzz;
    assign d1 = tb_drv ? wdata : 16'hzzzz;
    assign d2 = tb_drv ? wdata : 16'hzzzz;
    assign d3 = tb_drv ? wdata : 16'hzzzz;
    assign rdv  = {rv3, rv2, rv1, rv0};
    assign hits = {h3, h2, h1, h0};

    mem_responder #(.DEPTH(1024), .BASE(16'h0000), .RD_LAT(2)) u0 (
        .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memWr(wr), .i_memEn(en),
        .io_memData(d0), .o_rdValid(rv0), .o_hit(h0));
    mem_responder #(.DEPTH(1024), .BASE(16'h0000), .RD_LAT(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memWr(wr), .i_memEn(en),
        .io_memData(d1), .o_rdValid(rv1), .o_hit(h1));
    mem_responder #(.DEPTH(1024), .BASE(16'h0000), .RD_LAT(7)) u2 (
        .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memWr(wr), .i_memEn(en),
        .io_memData(d2), .o_rdValid(rv2), .o_hit(h2));
    mem_responder #(.DEPTH(1024), .BASE(16'h0400), .RD_LAT(2)) u3 (
        .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memWr(wr), .i_memEn(en),
        .io_memData(d3), .o_rdValid(rv3), .o_hit(h3));

    function automatic int lat_of(input int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 7;
            default: return 2;
        endcase
    endfunction

    function automatic logic m_hit(input int k, input logic [15:0] a);
        if (k == 3) return a[15:10] == 6'd1;
        return a[15:10] == 6'd0;
    endfunction

    function automatic logic [15:0] dat(input int k);
        case (k)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_hits();
        for (int k = 0; k < 4; k++)
            chk($sformatf("hit[%0d]", k), {31'b0, hits[k]}, {31'b0, en & m_hit(k, addr)});
    endtask

    task automatic chk_idle_bus(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s[%0d]", tag, k), {31'b0, rdv[k]}, 32'd0);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Idle cycle, one write cycle, idle cycle. Entered and left #1 after a posedge.
    task automatic wr_word(input logic [15:0] a, input logic [15:0] v);
        idle(1);
        addr = a; wr = 1'b1; en = 1'b1; wdata = v; tb_drv = 1'b1;
        #1 chk_hits();
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++)
            if (m_hit(k, a)) mem_m[k][a[9:0]] = v;
        tb_drv = 1'b0;
        idle(1);
    endtask

    // Hold a read of address a for 'hold' sampling edges. An instance answers
    // only when the address is held through its RD_LAT-th edge.
    task automatic rd(input logic [15:0] a, input int hold);
        int cs;
        addr = a; wr = 1'b0; en = 1'b1;
        cs = cyc;
        for (int k = 0; k < 4; k++)
            if (m_hit(k, a) && hold >= lat_of(k) + 1)
                sb_q.push_back('{k, mem_m[k][a[9:0]], cs + 1 + lat_of(k)});
        #1 chk_hits();
        repeat (hold) @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each rising edge of rdValid; flag expirations.
    always @(negedge clk) begin
        int found;
        for (int k = 0; k < 4; k++) begin
            if (rdv[k] && !rdv_prev[k]) begin
                found = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (sb_q[i].inst == k) begin
                        found = i;
                        break;
                    end
                end
                if (found < 0) begin
                    chk($sformatf("rd_unexpected[%0d]", k), {31'b0, rdv[k]}, 32'd0);
                end else begin
                    chk($sformatf("rd_data[%0d]", k), {16'b0, dat(k)}, {16'b0, sb_q[found].data});
                    chk($sformatf("rd_cycle[%0d]", k), cyc, sb_q[found].due);
                    sb_q.delete(found);
                end
            end
        end
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due < cyc) begin
                chk($sformatf("rd_missing[%0d]", sb_q[i].inst), cyc, sb_q[i].due);
                sb_q.delete(i);
            end
        end
        if (tb_drv) chk("bus_contention", {28'b0, rdv}, 32'd0);
        rdv_prev = rdv;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rdv_prev = 4'b0;
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = 16'h0; tb_drv = 1'b0; wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_bus("reset_rdvalid");
        chk_hits();
        rst = 1'b0;

        // Write then read of the same word.
        wr_word(16'h0005, 16'hBEEF);
        rd(16'h0005, 3);

        // Dropping enable in DRIVE releases the bus after the next edge.
        idle(1);
        chk_idle_bus("en_drop");

        for (int i = 0; i < 16; i++)
            wr_word(16'(i), 16'hA500 + 16'(i) * 16'h0011);

        // Address change during the wait phase restarts the latency.
        rd(16'h0003, 1);
        rd(16'h0004, 8);
        idle(1);

        // Out-of-window write must leave u3 untouched.
        wr_word(16'h0410, 16'h1234);
        wr_word(16'h0010, 16'h5678);
        rd(16'h0410, 3);
        idle(1);
        rd(16'h0010, 8);
        idle(1);

        // Reset with u0/u1 driving and u2 still waiting.
        rd(16'h0005, 3);
        @(negedge clk);
        #1;
        rst = 1'b1; en = 1'b0;
        #1;
        chk_idle_bus("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        rd(16'h0005, 8);
        idle(1);

        // Latency sweeps: long holds for all latencies, short holds for RD_LAT=1.
        for (int i = 0; i < 16; i++) rd(16'(i), 8);
        idle(2);
        for (int i = 0; i < 16; i++) rd(16'(i), 2);
        idle(12);

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the uP memory bus.
- Receives address/write/enable from the bus master and commits writes into an on-chip word RAM.
- Answers reads by driving the shared tristate data line after a programmable latency.
- Paired with the central memory controller; the controller drives io_memData only on writes, and this block drives it only during a granted read.

Parameters:
- DEPTH, 1024, number of 16-bit words; power of two, 2..32768; AW = log2(DEPTH).
- BASE, 16'h0000, decode base; must be aligned to DEPTH.
- RD_LAT, 2, read latency in cycles from accepted read to data driven; legal range 1..7.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_memAddr  in  16  bus word address.
- i_memWr  in  1  1 = write, 0 = read (qualified by i_memEn).
- i_memEn  in  1  bus access enable.
- io_memData  inout  16  shared data line; driven here only in DRIVE, else high-Z.
- o_rdValid  out  1  high while io_memData is being driven with valid read data.
- o_hit  out  1  combinational: i_memEn and address decodes into this block.

Behaviour:
- Decode: hit = i_memEn & (i_memAddr[15:AW] == BASE[15:AW]). RAM index = i_memAddr[AW-1:0]. Misses are ignored entirely: no write, no drive, FSM returns to IDLE.
- Reset (async assert, sync release):
  - state = IDLE, counter = 0, rdValid = 0, data-line drive disabled (high-Z), latched address = 0.
  - RAM contents are not reset (X in simulation).
- FSM states: IDLE, WAIT, DRIVE.
  - IDLE:
    - hit & wr: RAM[idx] <= io_memData at this edge; stay IDLE.
    - hit & !wr: latch idx, load counter = RD_LAT-1. Go to DRIVE if RD_LAT==1, else WAIT.
  - WAIT:
    - Each cycle: if hit & !wr & address == latched, decrement counter; at counter==1 (or 0 for RD_LAT==1) go to DRIVE.
    - Address change with hit & !wr: relatch and reload counter; latency restarts.
    - hit & wr: abort read, perform write this edge, go IDLE.
    - !hit: go IDLE.
  - DRIVE:
    - rdValid = 1; io_memData = registered RAM[latched idx].
    - Hold while hit & !wr & same address.
    - Address change: go WAIT with reload; rdValid and drive drop the next cycle.
    - wr or !hit: go IDLE; drive released by that edge.
- Latency: data appears on io_memData exactly RD_LAT rising edges after the edge at which the read was first sampled, with the address held stable.
- Drive enable is registered (no combinational path from i_memWr to the tristate enable), so at most one cycle of overlap if the master switches to write. The master must insert one idle or non-hit cycle between a read and a write; the bench flags violations.
- RAM read port is synchronous: read data is registered on the edge entering DRIVE.
- Write-then-read of the same address: the read returns the new value. The write commits before the read is latched, so no bypass is needed.
- Reset mid-read: drive released immediately (asynchronous), rdValid = 0.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state enum (IDLE/WAIT/DRIVE).
  - Bus width constant MEM_DW = 16, address width MEM_ADW = 16.
  - Function for the decode compare.
- Sub-module mem_responder_ram: single-port synchronous RAM (DEPTH x 16, write enable, registered read). This keeps the FPGA block-RAM inference isolated.
- The tristate itself stays inline as a single drive-enable assign in this block.

Test Plan:
- Write 16'hBEEF to addr 0x0005, idle 1 cycle, read 0x0005 held (RD_LAT=2) -> io_memData high-Z for 2 cycles, then 16'hBEEF with rdValid=1 from the 2nd edge after the read is sampled.
- Read 0x0003 then change to 0x0004 during WAIT -> counter restarts; data for 0x0004 appears RD_LAT edges after the change; 0x0003 data is never driven.
- BASE=16'h0400, DEPTH=1024: write to 0x0010 (miss) then read 0x0410 -> miss produces no write and o_hit=0; the read returns the prior RAM[0x10].
- In DRIVE, deassert i_memEn -> io_memData high-Z and rdValid=0 after the next edge; FSM IDLE.
- Assert i_rst during WAIT and during DRIVE -> drive and rdValid drop asynchronously; after release an immediate read behaves normally.
- RD_LAT=1 and RD_LAT=7 sweeps with back-to-back reads of 0x0000..0x000F -> each word is valid exactly RD_LAT edges after its address; no X is ever driven while rdValid=1.
